instr_mem_arbiter: RTL and testbench

INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

---
 rtl/instr_mem_arbiter.sv | 94 +++++++++
 tb/tb_instr_mem_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_arbiter.sv
// Two-port (fetch/debug) arbiter in front of a combinational instruction memory.
// Define IMEM_ARB_RR_EN for round-robin conflict resolution; default is fetch-over-debug priority.
module instr_mem_arbiter #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_0FFF,
   parameter logic [31:0] ERR_DATA   = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        f_req_i,
   input  logic [31:0] f_addr_i,
   output logic        f_gnt_o,
   output logic        f_rvalid_o,
   output logic [31:0] f_rdata_o,
   output logic        f_err_o,
   input  logic        d_req_i,
   input  logic [31:0] d_addr_i,
   output logic        d_gnt_o,
   output logic        d_rvalid_o,
   output logic [31:0] d_rdata_o,
   output logic        d_err_o,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_rdata_i
);
   logic        w_dbg_wins;
   logic        w_f_gnt;
   logic        w_d_gnt;
   logic        w_err;
   logic [31:0] w_mem_addr;
   logic [31:0] w_rdata;
   logic [31:0] r_last_addr;
   logic        r_f_rvalid, r_d_rvalid;
   logic        r_f_err, r_d_err;
   logic [31:0] r_f_rdata, r_d_rdata;

`ifdef IMEM_ARB_RR_EN
   // 1 = debug wins the next conflict; flips on every conflict so the loser goes next
   logic r_ptr_dbg;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                   r_ptr_dbg <= 1'b0;
      else if (f_req_i && d_req_i)   r_ptr_dbg <= ~r_ptr_dbg;
   end
   assign w_dbg_wins = r_ptr_dbg;
`else
   assign w_dbg_wins = 1'b0;
`endif

   // grants forced low while reset is asserted
   assign w_f_gnt = rst_ni & f_req_i & ~(d_req_i & w_dbg_wins);
   assign w_d_gnt = rst_ni & d_req_i & ~(f_req_i & ~w_dbg_wins);

   always_comb begin
      w_mem_addr = r_last_addr;
      if (w_f_gnt)      w_mem_addr = f_addr_i;
      else if (w_d_gnt) w_mem_addr = d_addr_i;
   end

   assign w_err   = (w_mem_addr > ADDR_LIMIT) || (w_mem_addr[1:0] != 2'b00);
   assign w_rdata = w_err ? ERR_DATA : mem_rdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_last_addr <= 32'h0;
         r_f_rvalid  <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_f_err     <= 1'b0;
         r_d_err     <= 1'b0;
         r_f_rdata   <= 32'h0;
         r_d_rdata   <= 32'h0;
      end else begin
         r_f_rvalid <= w_f_gnt;
         r_d_rvalid <= w_d_gnt;
         if (w_f_gnt || w_d_gnt) r_last_addr <= w_mem_addr;
         // data/err only move on acceptance so they hold while rvalid is low
         if (w_f_gnt) begin
            r_f_rdata <= w_rdata;
            r_f_err   <= w_err;
         end
         if (w_d_gnt) begin
            r_d_rdata <= w_rdata;
            r_d_err   <= w_err;
         end
      end
   end

   assign f_gnt_o    = w_f_gnt;
   assign d_gnt_o    = w_d_gnt;
   assign mem_addr_o = w_mem_addr;
   assign f_rvalid_o = r_f_rvalid;
   assign d_rvalid_o = r_d_rvalid;
   assign f_rdata_o  = r_f_rdata;
   assign d_rdata_o  = r_d_rdata;
   assign f_err_o    = r_f_err;
   assign d_err_o    = r_d_err;
endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Bench for instr_mem_arbiter: directed steps then random two-port traffic
// checked against a transaction-level arbitration/memory model.
module tb_instr_mem_arbiter;
   localparam logic [31:0] LIM  = 32'h0000_0FFF;
   localparam logic [31:0] ERRD = 32'hBADC_0DE5;
`ifdef IMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        f_req_i = 1'b0, d_req_i = 1'b0;
   logic [31:0] f_addr_i = '0, d_addr_i = '0;
   logic        f_gnt_o, f_rvalid_o, f_err_o, d_gnt_o, d_rvalid_o, d_err_o;
   logic [31:0] f_rdata_o, d_rdata_o, mem_addr_o, mem_rdata_i;

   logic [31:0] memw [0:1023];

   int n_chk = 0, n_fail = 0;
   int acc_f = 0, acc_d = 0, rsp_f = 0, rsp_d = 0;

   // model state: expected outputs for the current cycle
   logic        m_fv = 0, m_fe = 0, m_dv = 0, m_de = 0, m_ptr_dbg = 0;
   logic [31:0] m_fd = '0, m_dd = '0, m_last = '0;

   instr_mem_arbiter #(.ADDR_LIMIT(LIM), .ERR_DATA(ERRD)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
      .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
      .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_gnt_o(d_gnt_o),
      .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
      .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i));

   always #5 clk_i = ~clk_i;

   // combinational memory; out-of-range reads return junk the DUT must mask
   assign mem_rdata_i = (mem_addr_o <= LIM) ? memw[mem_addr_o[11:2]] : 32'hFFFF_FFFF;

   function automatic logic bad(input logic [31:0] a);
      return (a > LIM) || (a % 4 != 0);
   endfunction

   function automatic logic [31:0] rd(input logic [31:0] a);
      return bad(a) ? ERRD : memw[a / 4];
   endfunction

   function automatic logic [31:0] rand_addr();
      int k;
      k = $urandom_range(0, 15);
      if (k == 0) return $urandom;
      if (k == 1) return ($urandom_range(0, 1023) * 4) + $urandom_range(1, 3);
      if (k == 2) return 32'h0000_0FFC;
      if (k == 3) return 32'h0000_1000;
      return $urandom_range(0, 1023) * 4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " f_gnt"}, 32'(f_gnt_o), 0);
      chk({tag, " d_gnt"}, 32'(d_gnt_o), 0);
      chk({tag, " f_rvalid"}, 32'(f_rvalid_o), 0);
      chk({tag, " d_rvalid"}, 32'(d_rvalid_o), 0);
      chk({tag, " f_err"}, 32'(f_err_o), 0);
      chk({tag, " d_err"}, 32'(d_err_o), 0);
      chk({tag, " f_rdata"}, f_rdata_o, 0);
      chk({tag, " d_rdata"}, d_rdata_o, 0);
      chk({tag, " mem_addr"}, mem_addr_o, 0);
   endtask

   // one clock cycle: drive, check at negedge, advance the model, return the expected grants
   task automatic cyc(input logic fr, input logic [31:0] fa, input logic dr,
                      input logic [31:0] da, output logic gf, output logic gd);
      f_req_i = fr; f_addr_i = fa; d_req_i = dr; d_addr_i = da;
      @(negedge clk_i);
      if (fr && dr) begin
         gd = RR && m_ptr_dbg;
         gf = !gd;
         m_ptr_dbg = gf;
      end else begin
         gf = fr;
         gd = dr;
      end
      chk("f_gnt", 32'(f_gnt_o), 32'(gf));
      chk("d_gnt", 32'(d_gnt_o), 32'(gd));
      if (gf)      m_last = fa;
      else if (gd) m_last = da;
      chk("mem_addr", mem_addr_o, m_last);
      chk("f_rvalid", 32'(f_rvalid_o), 32'(m_fv));
      chk("d_rvalid", 32'(d_rvalid_o), 32'(m_dv));
      chk("f_rdata", f_rdata_o, m_fd);
      chk("f_err", 32'(f_err_o), 32'(m_fe));
      chk("d_rdata", d_rdata_o, m_dd);
      chk("d_err", 32'(d_err_o), 32'(m_de));
      if (f_rvalid_o) rsp_f++;
      if (d_rvalid_o) rsp_d++;
      m_fv = gf; m_dv = gd;
      if (gf) begin m_fe = bad(fa); m_fd = rd(fa); acc_f++; end
      if (gd) begin m_de = bad(da); m_dd = rd(da); acc_d++; end
      @(posedge clk_i); #1;
   endtask

   initial begin
      logic gf, gd;
      logic pf, pd;
      logic [31:0] pa, pda;
      int cycles;
      for (int i = 0; i < 1024; i++) memw[i] = (i < 16) ? i : $urandom;

      // reset with both ports requesting: everything must stay low
      f_req_i = 1; d_req_i = 1; f_addr_i = 32'h4; d_addr_i = 32'h8;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk_zero("reset");
      f_req_i = 0; d_req_i = 0;
      rst_ni = 1;
      @(posedge clk_i); #1;

      // fetch-only streaming, first grant on first edge after release
      cyc(1, 32'h0, 0, 0, gf, gd);
      cyc(1, 32'h4, 0, 0, gf, gd);
      cyc(1, 32'h8, 0, 0, gf, gd);
      cyc(0, 0, 0, 0, gf, gd);
      cyc(0, 0, 0, 0, gf, gd);

      // conflicts, then debug alone
      for (int i = 0; i < 4; i++) cyc(1, 32'h20 + 4 * i, 1, 32'h40, gf, gd);
      cyc(0, 0, 1, 32'h40, gf, gd);
      cyc(0, 0, 0, 0, gf, gd);

      // error and boundary addresses
      cyc(0, 0, 1, 32'h1000, gf, gd);
      cyc(1, 32'h2, 0, 0, gf, gd);
      cyc(1, 32'hFFC, 0, 0, gf, gd);
      cyc(0, 0, 1, 32'hFFFF_FFFC, gf, gd);
      cyc(0, 0, 0, 0, gf, gd);
      cyc(0, 0, 0, 0, gf, gd);

      // reset in the cycle after an acceptance
      f_req_i = 1; f_addr_i = 32'h10; d_req_i = 0;
      @(negedge clk_i);
      chk("midrst f_gnt", 32'(f_gnt_o), 1);
      rst_ni = 0;
      #1 chk_zero("midrst asserted");
      @(posedge clk_i); #1;
      chk_zero("midrst edge");
      @(negedge clk_i);
      f_req_i = 0;
      rst_ni = 1;
      m_fv = 0; m_dv = 0; m_fe = 0; m_de = 0; m_fd = '0; m_dd = '0;
      m_last = '0; m_ptr_dbg = 0;
      @(posedge clk_i); #1;
      cyc(0, 0, 0, 0, gf, gd);
      cyc(0, 0, 0, 0, gf, gd);

      // random traffic; requesters hold req/addr until granted
      acc_f = 0; acc_d = 0; rsp_f = 0; rsp_d = 0;
      pf = 0; pd = 0; pa = '0; pda = '0;
      cycles = 0;
      while ((acc_f + acc_d) < 4200 && cycles < 20000) begin
         if (!pf && $urandom_range(0, 3) != 0) begin pf = 1; pa = rand_addr(); end
         if (!pd && $urandom_range(0, 1) != 0) begin pd = 1; pda = rand_addr(); end
         cyc(pf, pa, pd, pda, gf, gd);
         if (gf) pf = 0;
         if (gd) pd = 0;
         cycles++;
      end
      cyc(0, 0, 0, 0, gf, gd);
      chk("rand enough accesses", 32'((acc_f + acc_d) >= 4096), 1);
      chk("rand fetch responses", rsp_f, acc_f);
      chk("rand debug responses", rsp_d, acc_d);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
